// File: rtl/incr_share_arbiter_pkg.sv
// Shared state encodings and default sizing for the shared-incrementer arbiter.
package incr_share_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_RESP = 2'b10
    } arb_state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_IDW   = 2;

endpackage

// File: rtl/incr_core.sv
// Combinational +1: ripple chain of full adders with the addend tied low and carry-in high.
module incr_core
    import incr_share_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] b;

    assign b    = '0;
    assign c[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign sum[WIDTH] = c[WIDTH];

endmodule

// File: rtl/incr_share_arbiter.sv
// Round-robin front end that time-shares one incr_core among NREQ requesters,
// one operation in flight, valid/ready on both sides.
module incr_share_arbiter
    import incr_share_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int IDW   = DEF_IDW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH:0]        rsp_sum,
    output logic                  busy
);

    arb_state_t       state, state_nxt;
    logic [IDW-1:0]   rr_ptr, id_q, win_id;
    logic [WIDTH-1:0] op_q, win_data;
    logic [WIDTH:0]   sum_q, core_sum;
    logic [NREQ-1:0]  rot;
    logic             win_vld;
    int               win_idx;

    // Rotate so bit 0 is the rr_ptr requester; the lowest set bit wins.
    always_comb begin
        rot     = NREQ'({req_valid, req_valid} >> rr_ptr);
        win_vld = 1'b0;
        win_idx = 0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                win_vld = 1'b1;
                win_idx = int'(rr_ptr) + j;
            end
        end
        if (win_idx >= NREQ) win_idx = win_idx - NREQ;
        win_id   = IDW'(win_idx);
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win_id) win_data = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Reset gating keeps req_ready low while rst_n is asserted even though state reads IDLE.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == S_IDLE && win_vld) begin
            for (int i = 0; i < NREQ; i++) begin
                if (IDW'(i) == win_id) req_ready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win_vld)   state_nxt = S_CALC;
            S_CALC:                 state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    incr_core #(.WIDTH(WIDTH)) u_core (
        .a   (op_q),
        .sum (core_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            op_q   <= '0;
            id_q   <= '0;
            sum_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && win_vld) begin
                op_q <= win_data;
                id_q <= win_id;
            end
            if (state == S_CALC) sum_q <= core_sum;
            if (state == S_RESP && rsp_ready) begin
                rr_ptr <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
            end
        end
    end

    assign rsp_valid = (state == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_incr_share_arbiter.sv
// Directed bench for incr_share_arbiter with a request/response scoreboard and protocol monitors.
module tb_incr_share_arbiter;

    localparam int W = 16;
    localparam int N = 4;
    localparam int I = 2;

    logic           clk, rst_n;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_data;
    logic           rsp_valid, rsp_ready, busy;
    logic [I-1:0]   rsp_id;
    logic [W:0]     rsp_sum;

    int n_chk = 0;
    int n_fail = 0;

    incr_share_arbiter #(.WIDTH(W), .NREQ(N), .IDW(I)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [W-1:0] v);
        req_data[i*W +: W] = v;
    endtask

    // Scoreboard and protocol monitor, sampled mid-way between negedge and posedge.
    int          exp_id[$];
    logic [W:0]  exp_sum[$];
    logic        have_prev = 1'b0, prev_v, prev_r;
    logic [I-1:0] prev_id;
    logic [W:0]  prev_sum;

    always @(negedge clk) begin
        #3;
        if (!rst_n) begin
            exp_id.delete();
            exp_sum.delete();
            have_prev = 1'b0;
        end else begin
            if (req_ready != '0) chk("grant_onehot", $countones(req_ready), 1);
            if (have_prev && prev_v && !prev_r) begin
                chk("hold_valid", rsp_valid, 1);
                chk("hold_id", rsp_id, prev_id);
                chk("hold_sum", rsp_sum, prev_sum);
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_id.push_back(i);
                    exp_sum.push_back({1'b0, req_data[i*W +: W]} + 17'd1);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_id.size() == 0) chk("rsp_unexpected", 1, 0);
                else begin
                    chk("sb_id", rsp_id, exp_id.pop_front());
                    chk("sb_sum", rsp_sum, exp_sum.pop_front());
                end
            end
            prev_v    = rsp_valid;
            prev_r    = rsp_ready;
            prev_id   = rsp_id;
            prev_sum  = rsp_sum;
            have_prev = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    int gid[5];
    int gcyc[5];
    int grants;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        // reset with every requester asking
        rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b1; req_data = '0;
        for (int i = 0; i < N; i++) set_data(i, 16'hAAAA);
        repeat (2) tick;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1; req_valid = '0;
        tick;

        // single request, latency t+2
        set_data(0, 16'h00FF); req_valid = 4'b0001;
        #1 chk("single_grant", req_ready, 4'b0001);
        tick;
        req_valid = '0;
        chk("single_busy", busy, 1);
        chk("single_calc_nvld", rsp_valid, 0);
        tick;
        chk("single_vld", rsp_valid, 1);
        chk("single_id", rsp_id, 0);
        chk("single_sum", rsp_sum, 17'h00100);
        tick;
        chk("single_done_vld", rsp_valid, 0);
        chk("single_done_busy", busy, 0);

        // all-ones operand reports carry
        set_data(2, 16'hFFFF); req_valid = 4'b0100;
        #1 chk("wrap_grant", req_ready, 4'b0100);
        tick;
        req_valid = '0;
        tick;
        chk("wrap_vld", rsp_valid, 1);
        chk("wrap_id", rsp_id, 2);
        chk("wrap_sum", rsp_sum, 17'h10000);
        tick;

        // reset pulse so fairness starts from rr_ptr=0
        rst_n = 1'b0; tick; rst_n = 1'b1; tick;

        // fairness: everyone valid, back-to-back service
        for (int i = 0; i < N; i++) set_data(i, 16'h1000 + 16'(i));
        req_valid = 4'hF; grants = 0;
        for (int c = 0; c < 40 && grants < 5; c++) begin
            #1;
            if (req_ready != '0) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) gid[grants] = i;
                gcyc[grants] = c;
                grants++;
            end
            tick;
        end
        req_valid = '0;
        chk("fair_count", grants, 5);
        for (int k = 0; k < 5; k++) chk("fair_order", gid[k], exp_order[k]);
        for (int k = 1; k < 5; k++) chk("fair_gap", gcyc[k] - gcyc[k-1], 3);
        repeat (3) tick;
        chk("fair_idle", busy, 0);

        // backpressure: rr_ptr is 1, only requester 0 valid
        set_data(0, 16'h1234); req_valid = 4'b0001; rsp_ready = 1'b0;
        #1 chk("bp_grant", req_ready, 4'b0001);
        tick;
        req_valid = 4'hF;
        tick;
        for (int k = 0; k < 5; k++) begin
            chk("bp_vld", rsp_valid, 1);
            chk("bp_id", rsp_id, 0);
            chk("bp_sum", rsp_sum, 17'h01235);
            chk("bp_no_grant", req_ready, 0);
            if (k < 4) tick;
        end
        rsp_ready = 1'b1;
        tick;
        chk("bp_done_vld", rsp_valid, 0);
        chk("bp_next_grant", req_ready, 4'b0010);
        req_valid = '0;
        tick;

        // reset during CALC discards the operation
        set_data(2, 16'h0005); req_valid = 4'b0100;
        #1 chk("mid_grant", req_ready, 4'b0100);
        tick;
        req_valid = '0;
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1 chk("mid_rst_busy", busy, 0);
        tick;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("mid_no_rsp", rsp_valid, 0);
        end
        req_valid = 4'b1010;
        #1 chk("mid_ptr0_grant", req_ready, 4'b0010);
        tick;
        req_valid = '0;
        tick;
        chk("mid_next_vld", rsp_valid, 1);
        chk("mid_next_id", rsp_id, 1);
        chk("mid_next_sum", rsp_sum, 17'h01002);
        repeat (2) tick;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
